// File: rtl/note_player.sv
// note_player: playback sequencer on the read side of the note memory.
// Define NOTE_PLAYER_LOOP_EN to repeat playback until stop or reset.
module note_player #(
   parameter int DATA_WIDTH  = 8,
   parameter int NOTE_CYCLES = 25_000_000,
   parameter int GAP_CYCLES  = 1_000_000,
   parameter int CNT_W       = 25
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  pause,
   output logic                  mem_read_rst,
   output logic                  mem_read_en,
   input  logic [DATA_WIDTH-1:0] mem_data,
   input  logic                  mem_ready,
   output logic [DATA_WIDTH-1:0] note_out,
   output logic                  note_valid,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REWIND,
      S_FETCH,
      S_CHECK,
      S_PLAY,
      S_GAP,
      S_FINISH
   } state_t;

   localparam logic [CNT_W-1:0] NOTE_LOAD = CNT_W'(NOTE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t                r_state;
   logic [CNT_W-1:0]      r_count;
   logic [DATA_WIDTH-1:0] r_note;
   logic                  r_memReadRst;
   logic                  r_memReadEn;
   logic                  r_busy;
   logic                  r_done;
`ifdef NOTE_PLAYER_LOOP_EN
   // Marks the CHECK that directly follows a rewind, so an empty memory cannot loop forever.
   logic                  r_firstCheck;
`endif

   // Strobes and done are raised on the transition into their state, so they are registered one-cycle pulses.
   always_ff @(posedge clk) begin
      if (!rst_n || stop) begin
         r_state      <= S_IDLE;
         r_count      <= '0;
         r_note       <= '0;
         r_memReadRst <= 1'b0;
         r_memReadEn  <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
`ifdef NOTE_PLAYER_LOOP_EN
         r_firstCheck <= 1'b0;
`endif
      end else begin
         r_memReadRst <= 1'b0;
         r_memReadEn  <= 1'b0;
         r_done       <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state      <= S_REWIND;
                  r_memReadRst <= 1'b1;
                  r_busy       <= 1'b1;
               end
            end
            S_REWIND: begin
               r_state     <= S_FETCH;
               r_memReadEn <= 1'b1;
`ifdef NOTE_PLAYER_LOOP_EN
               r_firstCheck <= 1'b1;
`endif
            end
            S_FETCH: begin
               r_state <= S_CHECK;
            end
            S_CHECK: begin
`ifdef NOTE_PLAYER_LOOP_EN
               r_firstCheck <= 1'b0;
`endif
               if (mem_ready) begin
                  r_state <= S_PLAY;
                  r_note  <= mem_data;
                  r_count <= NOTE_LOAD;
               end else begin
                  r_note <= '0;
`ifdef NOTE_PLAYER_LOOP_EN
                  if (r_firstCheck) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= S_FINISH;
                     r_done  <= 1'b1;
                  end
`else
                  r_state <= S_FINISH;
                  r_done  <= 1'b1;
`endif
               end
            end
            S_PLAY: begin
               if (!pause) begin
                  if (r_count == '0) begin
                     if (GAP_CYCLES > 0) begin
                        r_state <= S_GAP;
                        r_count <= GAP_LOAD;
                        r_note  <= '0;
                     end else begin
                        r_state     <= S_FETCH;
                        r_memReadEn <= 1'b1;
                     end
                  end else begin
                     r_count <= r_count - CNT_ONE;
                  end
               end
            end
            S_GAP: begin
               if (!pause) begin
                  if (r_count == '0) begin
                     r_state     <= S_FETCH;
                     r_memReadEn <= 1'b1;
                  end else begin
                     r_count <= r_count - CNT_ONE;
                  end
               end
            end
            S_FINISH: begin
               r_note <= '0;
`ifdef NOTE_PLAYER_LOOP_EN
               r_state      <= S_REWIND;
               r_memReadRst <= 1'b1;
`else
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
`endif
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_note  <= '0;
            end
         endcase
      end
   end

   assign mem_read_rst = r_memReadRst;
   assign mem_read_en  = r_memReadEn;
   assign note_out     = r_note;
   assign busy         = r_busy;
   assign done         = r_done;
   assign note_valid   = (r_state == S_PLAY) && (r_note != '0) && !pause;

endmodule

// File: tb/tb_note_player.sv
// Scoreboard bench for note_player: expected per-cycle outputs are queued when a
// playback is launched and compared cycle by cycle at the falling edge.
module tb_note_player;

   localparam int NOTE = 4;
   localparam int GAP  = 2;
`ifdef NOTE_PLAYER_LOOP_EN
   localparam bit LOOP_EN = 1'b1;
`else
   localparam bit LOOP_EN = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic       pause;
   logic       mem_read_rst;
   logic       mem_read_en;
   logic [7:0] mem_data;
   logic       mem_ready;
   logic [7:0] note_out;
   logic       note_valid;
   logic       busy;
   logic       done;

   logic [7:0]  noteMem [0:2];
   int          memLen;
   int          memPtr;
   logic [12:0] expQ [$];
   int          checkCount;
   int          passCount;
   int          rstCount;
   int          enCount;
   int          stopCycle;

   note_player #(
      .DATA_WIDTH (8),
      .NOTE_CYCLES(NOTE),
      .GAP_CYCLES (GAP),
      .CNT_W      (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stop        (stop),
      .pause       (pause),
      .mem_read_rst(mem_read_rst),
      .mem_read_en (mem_read_en),
      .mem_data    (mem_data),
      .mem_ready   (mem_ready),
      .note_out    (note_out),
      .note_valid  (note_valid),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Note memory model: data and ready valid the cycle after a read request.
   always @(posedge clk) begin
      if (!rst_n) begin
         memPtr    <= 0;
         mem_ready <= 1'b0;
         mem_data  <= 8'h00;
      end else if (mem_read_rst) begin
         memPtr <= 0;
      end else if (mem_read_en) begin
         if (memPtr < memLen) begin
            mem_data  <= noteMem[memPtr];
            mem_ready <= 1'b1;
         end else begin
            mem_data  <= 8'h00;
            mem_ready <= 1'b0;
         end
         memPtr <= memPtr + 1;
      end
   end

   function automatic logic [12:0] packOut(input logic r, input logic e, input logic d,
                                           input logic b, input logic v, input logic [7:0] n);
      return {r, e, d, b, v, n};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp)
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         passCount++;
   endtask

   task automatic applyStimulus(input logic st, input logic sp, input logic pa, input logic rn);
      @(posedge clk);
      #1;
      start = st;
      stop  = sp;
      pause = pa;
      rst_n = rn;
      @(negedge clk);
      if (mem_read_rst) rstCount++;
      if (mem_read_en)  enCount++;
   endtask

   // Expected trace of a playback started in cycle 0, derived from the documented timing.
   task automatic buildExpected(input int nNotes, input int pauseAt, input int pauseLen,
                                input int cutAt, output int stopAt);
      int c;
      int rem;
      logic p;
      logic [7:0] nt;
      expQ.delete();
      stopAt = cutAt;
      expQ.push_back(packOut(0, 0, 0, 0, 0, 8'h00));
      expQ.push_back(packOut(1, 0, 0, 1, 0, 8'h00));
      expQ.push_back(packOut(0, 1, 0, 1, 0, 8'h00));
      expQ.push_back(packOut(0, 0, 0, 1, 0, 8'h00));
      c = 4;
      for (int i = 0; i < nNotes; i++) begin
         nt  = noteMem[i];
         rem = NOTE;
         while (rem > 0) begin
            p = (c >= pauseAt) && (c < pauseAt + pauseLen);
            expQ.push_back(packOut(0, 0, 0, 1, (nt != 8'h00) && !p, nt));
            if (!p) rem--;
            c++;
         end
         rem = GAP;
         while (rem > 0) begin
            p = (c >= pauseAt) && (c < pauseAt + pauseLen);
            expQ.push_back(packOut(0, 0, 0, 1, 0, 8'h00));
            if (!p) rem--;
            c++;
         end
         expQ.push_back(packOut(0, 1, 0, 1, 0, 8'h00));
         expQ.push_back(packOut(0, 0, 0, 1, 0, 8'h00));
         c += 2;
      end
      if (LOOP_EN && nNotes == 0) begin
         expQ.push_back(packOut(0, 0, 0, 0, 0, 8'h00));
         c++;
      end else begin
         expQ.push_back(packOut(0, 0, 1, 1, 0, 8'h00));
         c++;
         if (LOOP_EN) begin
            expQ.push_back(packOut(1, 0, 0, 1, 0, 8'h00));
            if (stopAt < 0) stopAt = c;
            c++;
         end else begin
            expQ.push_back(packOut(0, 0, 0, 0, 0, 8'h00));
            c++;
         end
      end
      if (stopAt >= 0) begin
         while (expQ.size() > stopAt + 1) void'(expQ.pop_back());
         expQ.push_back(packOut(0, 0, 0, 0, 0, 8'h00));
         expQ.push_back(packOut(0, 0, 0, 0, 0, 8'h00));
      end else begin
         expQ.push_back(packOut(0, 0, 0, 0, 0, 8'h00));
      end
   endtask

   task automatic runTest(input string name, input int pauseAt, input int pauseLen,
                          input int stopAt, input int rstAt, input int startAt);
      int c;
      logic [12:0] exp;
      c        = 0;
      rstCount = 0;
      enCount  = 0;
      while (expQ.size() > 0 && c < 300) begin
         applyStimulus((c == 0) || (c == startAt), c == stopAt,
                       (c >= pauseAt) && (c < pauseAt + pauseLen), !(c == rstAt));
         exp = expQ.pop_front();
         checkOutput($sformatf("%s cyc%0d", name, c),
                     32'({mem_read_rst, mem_read_en, done, busy, note_valid, note_out}),
                     32'(exp));
         c++;
      end
      if (expQ.size() > 0)
         checkOutput({name, " timeout"}, 32'(expQ.size()), 32'd0);
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      rstCount   = 0;
      enCount    = 0;
      rst_n      = 1'b0;
      start      = 1'b0;
      stop       = 1'b0;
      pause      = 1'b0;
      noteMem[0] = 8'h00;
      noteMem[1] = 8'h15;
      noteMem[2] = 8'h23;
      memLen     = 3;

      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
         checkOutput("reset", 32'({mem_read_rst, mem_read_en, done, busy, note_valid, note_out}), 32'd0);
      end

      $display("[TB] single pass");
      buildExpected(3, -1, 0, -1, stopCycle);
      runTest("single", -1, 0, stopCycle, -1, -1);
      checkOutput("single rstPulses", 32'(rstCount), LOOP_EN ? 32'd2 : 32'd1);
      checkOutput("single enPulses", 32'(enCount), 32'd4);

      $display("[TB] start ignored while busy");
      buildExpected(3, -1, 0, -1, stopCycle);
      runTest("ignoredStart", -1, 0, stopCycle, -1, 6);
      checkOutput("ignoredStart rstPulses", 32'(rstCount), LOOP_EN ? 32'd2 : 32'd1);

      $display("[TB] pause during 0x15");
      buildExpected(3, 13, 3, -1, stopCycle);
      runTest("pause", 13, 3, stopCycle, -1, -1);

      $display("[TB] stop during 0x15 then replay");
      buildExpected(3, -1, 0, 13, stopCycle);
      runTest("stop", -1, 0, stopCycle, -1, -1);
      checkOutput("stop enPulses", 32'(enCount), 32'd2);
      buildExpected(3, -1, 0, -1, stopCycle);
      runTest("replay", -1, 0, stopCycle, -1, -1);

      $display("[TB] start and stop together in idle");
      expQ.delete();
      for (int i = 0; i < 4; i++) expQ.push_back(packOut(0, 0, 0, 0, 0, 8'h00));
      runTest("startStop", -1, 0, 0, -1, -1);
      checkOutput("startStop rstPulses", 32'(rstCount), 32'd0);

      $display("[TB] reset mid-note");
      buildExpected(3, -1, 0, 14, stopCycle);
      runTest("midReset", -1, 0, -1, 14, -1);

      $display("[TB] empty memory");
      memLen = 0;
      buildExpected(0, -1, 0, -1, stopCycle);
      runTest("empty", -1, 0, stopCycle, -1, -1);
      checkOutput("empty enPulses", 32'(enCount), 32'd1);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/note_player.md
# note_player

Playback sequencer on the read side of the note memory. On `start` it rewinds the memory read pointer, then fetches stored notes one at a time with a single-cycle read handshake. Each note is held on `note_out` for a fixed duration, optionally followed by a silent gap. `done` pulses when the memory reports no further notes. It feeds the tone generator/buzzer driver and sits beside the recorder in the top level.

## Interface
- `DATA_WIDTH`, 8: note/octave code width; must match the memory word width.
- `NOTE_CYCLES`, 25_000_000: clock cycles each note is held; must be ≥1.
- `GAP_CYCLES`, 1_000_000: silent clock cycles after each note; 0 disables the gap.
- `CNT_W`, 25: counter width; must hold max(NOTE_CYCLES, GAP_CYCLES)−1.
- `clk` in 1: clock, all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: begin playback; sampled in IDLE only.
- `stop` in 1: abort playback from any state.
- `pause` in 1: level; freezes the duration counters and mutes output.
- `mem_read_rst` out 1: one-cycle pulse that rewinds the memory read pointer.
- `mem_read_en` out 1: one-cycle read request.
- `mem_data` in DATA_WIDTH: memory data, valid the cycle after `mem_read_en`.
- `mem_ready` in 1: memory output-ready flag, valid the cycle after `mem_read_en`.
- `note_out` out DATA_WIDTH: current note code to the tone generator; 0 means rest.
- `note_valid` out 1: high while a non-zero note is sounding.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at natural end of playback.

## Operation
- States: IDLE, REWIND, FETCH, CHECK, PLAY, GAP, FINISH.
- IDLE → REWIND when `start`=1. REWIND drives `mem_read_rst`=1 for one cycle → FETCH.
- FETCH drives `mem_read_en`=1 for one cycle → CHECK.
- CHECK samples `mem_ready`:
  - 1 → PLAY. Load `note_out`←`mem_data` and counter←NOTE_CYCLES−1.
  - 0 → FINISH.
- PLAY: each cycle with `pause`=0, counter decrements. At counter=0 and `pause`=0:
  - GAP_CYCLES>0 → GAP, counter←GAP_CYCLES−1, `note_out`←0.
  - GAP_CYCLES=0 → FETCH.
- GAP: same countdown and pause rules as PLAY; at 0 → FETCH.
- FINISH: `note_out`←0, `done`=1 for one cycle → IDLE.
- `note_out` holds the previous note through FETCH/CHECK when there is no gap, so there is no glitch between notes.
- `note_valid` = (state==PLAY) & (`note_out`≠0) & ~`pause`.
- Pause handling:
  - While `pause`=1 in PLAY, `note_valid`=0 and the counter holds. The note resumes with its remaining duration when pause drops.
  - Pause does not delay REWIND, FETCH, CHECK or FINISH.
- Stored value 0 is a rest: played for its full duration with `note_valid`=0.
- `stop`=1 in any state: next cycle IDLE, `note_out`=0, no `done` pulse, no memory strobe issued that cycle. `stop` takes priority over `start` in the same cycle.
- `start` while `busy`=1 is ignored.
- At most one of `mem_read_rst`/`mem_read_en` is high in any cycle; both are only ever high for one cycle at a time.

## Timing
- Reset values: state IDLE, all outputs 0, counter 0. Reset mid-playback behaves as `stop` but takes effect on the reset edge.
- Start latency:
  - `start` sampled at edge 0.
  - `mem_read_rst`=1 during cycle 1.
  - `mem_read_en`=1 during cycle 2.
  - CHECK in cycle 3.
  - `note_out` valid from cycle 4.
- PLAY occupies exactly NOTE_CYCLES cycles, plus one cycle for each cycle `pause` is high. GAP occupies exactly GAP_CYCLES cycles under the same pause rule.
- Note-to-note period: NOTE_CYCLES+GAP_CYCLES+2 cycles (FETCH+CHECK).
- Empty memory: `done` pulses in cycle 4 after `start`. `note_valid` never rises.
- Outputs are registered, except `note_valid`, which is decoded from registered state and the `pause` input.

## Configuration
- `NOTE_PLAYER_LOOP_EN` defined:
  - In FINISH, `done` still pulses, but the next state is REWIND, so playback repeats until `stop` or reset.
  - If the CHECK immediately following REWIND sees `mem_ready`=0 (empty memory), go to IDLE instead to prevent an endless empty loop.
- `NOTE_PLAYER_LOOP_EN` undefined: FINISH → IDLE; single pass.

## Test plan
Bench uses NOTE_CYCLES=4, GAP_CYCLES=2, and a memory model preloaded with 0x00, 0x15, 0x23.
- Single pass: pulse `start` → `note_out` 0x00 (4 cycles, `note_valid`=0), 0 (2 cycles), 0x15 (4 cycles, `note_valid`=1), …, 0x23; then `done` one cycle; `busy` falls; exactly one `mem_read_rst` and four `mem_read_en` pulses.
- Empty memory: `start` → `mem_read_rst` in cycle 1, `mem_read_en` in cycle 2, `done` in cycle 4, `note_out` stays 0.
- Pause: assert `pause` for 3 cycles in the middle of 0x15 → `note_valid`=0 during pause; 0x15 total PLAY time is 7 cycles; the following sequence shifts by 3 cycles.
- Stop: assert `stop` during 0x15 PLAY → next cycle IDLE, `note_out`=0, no `done`. A new `start` replays from 0x00.
- Simultaneous/ignored: `start`+`stop` in the same cycle in IDLE → stays IDLE. `start` during PLAY → no extra `mem_read_rst`.
- With `NOTE_PLAYER_LOOP_EN`: after 0x23, `done` pulses, then `mem_read_rst` in the next cycle and 0x00 plays again. Reset mid-note → all outputs 0 on the next edge.
